// File: rtl/apb_req_master.sv
// APB requester: takes single commands on a valid/ready port, decodes them to a one-hot
// PSEL, runs SETUP/ACCESS with wait states and reports read data, slave errors and timeouts.
module apb_req_master #(
  parameter int AWIDTH           = 4,
  parameter int DWIDTH           = 32,
  parameter int REGWN            = 5,
  parameter int REGRN            = 3,
  parameter int REGR_ADDR_OFFSET = 5,
  parameter int TIMEOUT          = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [AWIDTH-1:0]      cmd_addr,
  input  logic [DWIDTH-1:0]      cmd_wdata,
  output logic                   rsp_valid,
  output logic [DWIDTH-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [REGWN+REGRN-1:0] PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [AWIDTH-1:0]      PADDR,
  output logic [DWIDTH-1:0]      PWDATA,
  input  logic [DWIDTH-1:0]      PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  localparam int PSW = REGWN + REGRN;
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  wait_cnt;
  logic [PSW-1:0] sel_dec;
  logic           is_rw;
  logic           is_ro;
  logic           legal;
  logic           tmo_hit;
  logic [31:0]    addr_ext;

  assign addr_ext = 32'(cmd_addr);

  // Address decode: RW block at 0.., RO block at REGR_ADDR_OFFSET..; anything else is unmapped
  always_comb begin
    sel_dec = '0;
    is_rw   = 1'b0;
    is_ro   = 1'b0;
    for (int i = 0; i < REGWN; i++) begin
      if (addr_ext == 32'(i)) begin
        sel_dec[i] = 1'b1;
        is_rw      = 1'b1;
      end
    end
    for (int j = 0; j < REGRN; j++) begin
      if (addr_ext == 32'(REGR_ADDR_OFFSET + j)) begin
        sel_dec[REGWN+j] = 1'b1;
        is_ro            = 1'b1;
      end
    end
  end

  assign legal     = is_rw | (is_ro & ~cmd_write);
  assign cmd_ready = (state == ST_IDLE);
  // Abort on the ACCESS cycle that would bring the wait count up to TIMEOUT
  assign tmo_hit   = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (legal) begin
              state    <= ST_SETUP;
              wait_cnt <= '0;
              PSEL     <= sel_dec;
              PADDR    <= cmd_addr;
              PWRITE   <= cmd_write;
              if (cmd_write) begin
                PWDATA <= cmd_wdata;
              end
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            state     <= ST_IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
          end else if (tmo_hit) begin
            state     <= ST_IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// Scoreboard bench for apb_req_master: a reference model predicts each response and its
// arrival cycle, a slave model serves the bus, and a monitor checks every rsp_valid pulse.
module tb_apb_req_master;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int RWN  = 5;
  localparam int RON  = 3;
  localparam int ROFF = 5;
  localparam int TMO  = 16;
  localparam int PSW  = RWN + RON;

  logic          PCLK;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [PSW-1:0] PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  typedef struct {
    int          wt;
    logic        err;
    logic [7:0]  sel;
    logic [3:0]  addr;
    logic        wr;
    logic [31:0] wdata;
  } plan_t;

  rsp_t        sb[$];
  plan_t       planq[$];
  logic [31:0] ref_mem[RWN];
  logic [31:0] slv_mem[RWN];
  logic [31:0] ro_val[RON];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  apb_req_master #(
    .AWIDTH(AW), .DWIDTH(DW), .REGWN(RWN), .REGRN(RON),
    .REGR_ADDR_OFFSET(ROFF), .TIMEOUT(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    forever begin
      @(posedge PCLK);
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check_output("rst_psel", 32'(PSEL), 32'h0);
    check_output("rst_penable", 32'(PENABLE), 32'h0);
    check_output("rst_pwrite", 32'(PWRITE), 32'h0);
    check_output("rst_paddr", 32'(PADDR), 32'h0);
    check_output("rst_pwdata", PWDATA, 32'h0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_output("rst_rsp_err", 32'(rsp_err), 32'h0);
    check_output("rst_cmd_ready", 32'(cmd_ready), 32'h1);
  endtask

  // Issue one command (called at a negedge); the model predicts result and arrival cycle
  task automatic apply_stimulus(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                                input int wt, input logic serr);
    int    n = 0;
    int    a;
    int    acc;
    rsp_t  r;
    plan_t p;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (!cmd_ready && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) begin
      check_output("accept_wait", 32'(cmd_ready), 32'h1);
      cmd_valid = 1'b0;
      return;
    end
    a   = int'(addr);
    acc = cyc + 1;
    r.err   = 1'b0;
    r.rdata = 32'h0;
    if (a < RWN || (a >= ROFF && a < ROFF + RON && !wr)) begin
      p.wt    = wt;
      p.err   = serr;
      p.sel   = (a < RWN) ? 8'(1 << a) : 8'(1 << (RWN + a - ROFF));
      p.addr  = addr;
      p.wr    = wr;
      p.wdata = wdata;
      planq.push_back(p);
      if (wt >= TMO) begin
        r.err = 1'b1;
        r.cyc = acc + 1 + TMO;
      end else begin
        r.cyc = acc + 2 + wt;
        if (serr) begin
          r.err = 1'b1;
        end else if (wr) begin
          ref_mem[a] = wdata;
        end else begin
          r.rdata = (a < RWN) ? ref_mem[a] : ro_val[a - ROFF];
        end
      end
    end else begin
      r.err = 1'b1;
      r.cyc = acc;
    end
    sb.push_back(r);
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  // Slave: serves each transfer with the wait states and error chosen when it was issued
  initial begin
    plan_t cur;
    int    wl   = 0;
    int    idx  = 0;
    logic  in_x = 1'b0;
    cur.wt = 0; cur.err = 1'b0; cur.sel = 8'h0; cur.addr = 4'h0; cur.wr = 1'b0; cur.wdata = 32'h0;
    PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
      if (!PRESETn) begin
        in_x = 1'b0;
      end else if (PSEL != 0 && !PENABLE) begin
        if (planq.size() == 0) begin
          check_output("unexpected_setup", 32'(PSEL), 32'h0);
          cur.wt = 0; cur.err = 1'b0;
        end else begin
          cur = planq.pop_front();
          check_output("setup_psel", 32'(PSEL), 32'(cur.sel));
          check_output("setup_paddr", 32'(PADDR), 32'(cur.addr));
          check_output("setup_pwrite", 32'(PWRITE), 32'(cur.wr));
          if (cur.wr) check_output("setup_pwdata", PWDATA, cur.wdata);
        end
        wl   = cur.wt;
        in_x = 1'b1;
      end else if (in_x && PSEL != 0 && PENABLE) begin
        if (wl == 0) begin
          idx = -1;
          for (int i = 0; i < PSW; i++) if (PSEL[i]) idx = i;
          PREADY  = 1'b1;
          PSLVERR = cur.err;
          if (cur.err) begin
            PRDATA = $urandom;
          end else if (PWRITE) begin
            if (idx >= 0 && idx < RWN) slv_mem[idx] = PWDATA;
            PRDATA = $urandom;
          end else if (idx >= 0 && idx < RWN) begin
            PRDATA = slv_mem[idx];
          end else if (idx >= RWN) begin
            PRDATA = ro_val[idx - RWN];
          end
          in_x = 1'b0;
        end else begin
          wl--;
        end
      end
    end
  end

  // Monitor: every response pulse is matched against the oldest prediction
  initial begin
    rsp_t r;
    forever begin
      @(negedge PCLK);
      if (PRESETn && rsp_valid) begin
        if (sb.size() == 0) begin
          check_output("unexpected_rsp", 32'(rsp_valid), 32'h0);
        end else begin
          r = sb.pop_front();
          check_output("rsp_err", 32'(rsp_err), 32'(r.err));
          check_output("rsp_rdata", rsp_rdata, r.rdata);
          check_output("rsp_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
      if (PSEL != 0) check_output("psel_onehot", 32'($onehot(PSEL)), 32'h1);
    end
  end

  initial begin
    int n;
    int s;
    logic        wr;
    logic [3:0]  addr;
    int          wt;
    logic        serr;
    for (int i = 0; i < RWN; i++) begin
      ref_mem[i] = 32'h0;
      slv_mem[i] = 32'h0;
    end
    ro_val[0] = 32'hC0DE_0000;
    ro_val[1] = 32'h0000_1234;
    ro_val[2] = 32'hBEEF_0002;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 4'h0;
    cmd_wdata = 32'h0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    apply_stimulus(1'b1, 4'd2, 32'hA5A5_0001, 0, 1'b0);
    apply_stimulus(1'b0, 4'd6, 32'h0, 3, 1'b0);
    apply_stimulus(1'b1, 4'd5, 32'h1111_1111, 0, 1'b0);
    apply_stimulus(1'b0, 4'd9, 32'h0, 0, 1'b0);
    apply_stimulus(1'b0, 4'd1, 32'h0, 20, 1'b0);
    apply_stimulus(1'b0, 4'd2, 32'h0, 1, 1'b1);
    apply_stimulus(1'b1, 4'd3, 32'h3333_0003, 0, 1'b0);
    apply_stimulus(1'b0, 4'd2, 32'h0, 0, 1'b0);
    apply_stimulus(1'b0, 4'd4, 32'h0, TMO - 1, 1'b0);
    apply_stimulus(1'b0, 4'd0, 32'h0, TMO, 1'b0);
    apply_stimulus(1'b0, 4'd3, 32'h0, 2, 1'b0);

    for (int k = 0; k < 150; k++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      s    = $urandom_range(0, 9);
      wt   = (s < 8) ? $urandom_range(0, 3) : ((s == 8) ? $urandom_range(TMO - 2, TMO + 1) : 20);
      serr = ($urandom_range(0, 6) == 0);
      apply_stimulus(wr, addr, $urandom, wt, serr);
    end

    apply_stimulus(1'b0, 4'd7, 32'h0, 30, 1'b0);
    n = 0;
    while (!PENABLE && n < 10) begin
      @(negedge PCLK);
      n++;
    end
    check_output("reach_access", 32'(PENABLE), 32'h1);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    planq.delete();
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (25) @(negedge PCLK);
    apply_stimulus(1'b0, 4'd6, 32'h0, 0, 1'b0);
    apply_stimulus(1'b0, 4'd3, 32'h0, 1, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    check_output("sb_drain", 32'(sb.size()), 32'h0);
    check_output("plan_drain", 32'(planq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
